// File: rtl/param_seq_fsm.sv
// rtl/param_seq_fsm.sv - parametrised phase sequencer with hold/step/run/jump commands
module param_seq_fsm #(
    parameter int STATE_W    = 3,
    parameter int NUM_STATES = 6,
    parameter int DWELL_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         user_input,
    input  logic [STATE_W-1:0] jump_tgt,
    input  logic [DWELL_W-1:0] dwell_cfg,
    input  logic               lock_req,
    output logic [STATE_W-1:0] out,
    output logic               wrap,
    output logic               err,
    output logic               locked
);

    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_STEP = 2'b01,
        CMD_RUN  = 2'b10,
        CMD_JUMP = 2'b11
    } cmd_t;

    // One extra bit so the bound compares cleanly even when NUM_STATES == 2**STATE_W.
    localparam logic [STATE_W:0]   NUM_S      = NUM_STATES[STATE_W:0];
    localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);

    logic [STATE_W-1:0] r_state;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic               r_wrap;
    logic               r_err;
    logic               r_locked;

    logic [STATE_W-1:0] w_state_nxt;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic               w_wrap_nxt;
    logic               w_err_nxt;
    logic               w_locked_nxt;
    logic               w_illegal;
    logic               w_tgt_ok;
    logic               w_last;
    logic [STATE_W-1:0] w_adv_state;
    cmd_t               w_cmd;

    assign w_cmd       = cmd_t'(user_input);
    assign w_illegal   = ({1'b0, r_state} >= NUM_S);
    assign w_tgt_ok    = ({1'b0, jump_tgt} < NUM_S);
    assign w_last      = (r_state == LAST_STATE);
    assign w_adv_state = w_last ? '0 : r_state + 1'b1;

    // State register and flags; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= '0;
            r_dwell_cnt <= '0;
            r_wrap      <= 1'b0;
            r_err       <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            r_wrap      <= w_wrap_nxt;
            r_err       <= w_err_nxt;
            r_locked    <= w_locked_nxt;
        end
    end

    // Next-state decode: lock beats illegal-state recovery, which beats the command.
    always_comb begin
        w_state_nxt  = r_state;
        w_dwell_nxt  = r_dwell_cnt;
        w_wrap_nxt   = 1'b0;
        w_err_nxt    = r_err;
        w_locked_nxt = r_locked;

        if (r_locked) begin
            // Frozen until reset; inputs ignored.
            w_state_nxt = r_state;
        end else if (w_illegal) begin
            // Recovery wins over a same-cycle lock_req so the FSM never
            // freezes in an illegal encoding; the lock still takes effect.
            w_state_nxt  = '0;
            w_dwell_nxt  = '0;
            w_err_nxt    = 1'b1;
            w_locked_nxt = lock_req;
        end else if (lock_req) begin
            w_locked_nxt = 1'b1;
        end else begin
            case (w_cmd)
                CMD_HOLD: begin
                    w_dwell_nxt = '0;
                end
                CMD_STEP: begin
                    w_state_nxt = w_adv_state;
                    w_dwell_nxt = '0;
                    w_wrap_nxt  = w_last;
                end
                CMD_RUN: begin
                    // >= rather than == so a dwell_cfg lowered below the
                    // running count advances at once instead of wrapping.
                    if (r_dwell_cnt >= dwell_cfg) begin
                        w_state_nxt = w_adv_state;
                        w_dwell_nxt = '0;
                        w_wrap_nxt  = w_last;
                    end else begin
                        w_dwell_nxt = r_dwell_cnt + 1'b1;
                    end
                end
                CMD_JUMP: begin
                    if (w_tgt_ok) begin
                        w_state_nxt = jump_tgt;
                        w_dwell_nxt = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign out    = r_state;
    assign wrap   = r_wrap;
    assign err    = r_err;
    assign locked = r_locked;

endmodule

// File: tb/tb_param_seq_fsm.sv
// tb/tb_param_seq_fsm.sv - directed self-checking bench for param_seq_fsm
module tb_param_seq_fsm;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] STEP = 2'b01;
    localparam logic [1:0] RUN  = 2'b10;
    localparam logic [1:0] JUMP = 2'b11;

    logic       clk;
    logic       rst_n;
    logic [1:0] user_input;
    logic [2:0] jump_tgt;
    logic [3:0] dwell_cfg;
    logic       lock_req;
    logic [2:0] out;
    logic       wrap;
    logic       err;
    logic       locked;

    int checks;
    int errors;

    param_seq_fsm #(
        .STATE_W   (3),
        .NUM_STATES(6),
        .DWELL_W   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .user_input(user_input),
        .jump_tgt  (jump_tgt),
        .dwell_cfg (dwell_cfg),
        .lock_req  (lock_req),
        .out       (out),
        .wrap      (wrap),
        .err       (err),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_out, input logic e_wrap,
                             input logic e_err, input logic e_locked);
        check({tag, ".out"}, {5'd0, out}, {5'd0, e_out});
        check({tag, ".wrap"}, {7'd0, wrap}, {7'd0, e_wrap});
        check({tag, ".err"}, {7'd0, err}, {7'd0, e_err});
        check({tag, ".locked"}, {7'd0, locked}, {7'd0, e_locked});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [2:0] exp_step [7];
    logic [2:0] exp_run  [9];
    logic [1:0] lock_cmds[3];

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        user_input = HOLD;
        jump_tgt   = 3'd0;
        dwell_cfg  = 4'd0;
        lock_req   = 1'b0;
        exp_step   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        exp_run    = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
        lock_cmds  = '{STEP, RUN, JUMP};

        // Reset state
        repeat (2) @(negedge clk);
        check_all("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // 1. STEP walk with wrap
        user_input = STEP;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_all($sformatf("step%0d", i), exp_step[i], (exp_step[i] == 3'd0), 1'b0, 1'b0);
        end
        user_input = HOLD;
        tick();
        check_all("hold", 3'd1, 1'b0, 1'b0, 1'b0);

        // 2. RUN with dwell_cfg=2 starting from state 0
        user_input = JUMP;
        jump_tgt   = 3'd0;
        tick();
        check_all("jump0", 3'd0, 1'b0, 1'b0, 1'b0);
        user_input = RUN;
        dwell_cfg  = 4'd2;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_all($sformatf("run%0d", i), exp_run[i], 1'b0, 1'b0, 1'b0);
        end
        // RUN dwell_cfg=0 from 3: advance each cycle, wrap on 5->0
        dwell_cfg = 4'd0;
        tick(); check_all("run0cfg_a", 3'd4, 1'b0, 1'b0, 1'b0);
        tick(); check_all("run0cfg_b", 3'd5, 1'b0, 1'b0, 1'b0);
        tick(); check_all("run0cfg_c", 3'd0, 1'b1, 1'b0, 1'b0);
        tick(); check_all("run0cfg_d", 3'd1, 1'b0, 1'b0, 1'b0);

        // 3. JUMP legal/illegal targets
        user_input = JUMP;
        jump_tgt   = 3'd4;
        tick(); check_all("jump4", 3'd4, 1'b0, 1'b0, 1'b0);
        jump_tgt = 3'd7;
        tick(); check_all("jump7", 3'd4, 1'b0, 1'b1, 1'b0);
        jump_tgt = 3'd5;
        tick(); check_all("jump5", 3'd5, 1'b0, 1'b1, 1'b0);
        jump_tgt = 3'd6;
        tick(); check_all("jump6", 3'd5, 1'b0, 1'b1, 1'b0);
        jump_tgt = 3'd0;
        tick(); check_all("jump5to0", 3'd0, 1'b0, 1'b1, 1'b0);
        user_input = STEP;
        tick(); check_all("err_sticky_a", 3'd1, 1'b0, 1'b1, 1'b0);
        tick(); check_all("err_sticky_b", 3'd2, 1'b0, 1'b1, 1'b0);

        // 4. Illegal-state recovery
        user_input = HOLD;
        do_reset();
        check_all("reset2", 3'd0, 1'b0, 1'b0, 1'b0);
        force dut.r_state = 3'd6;
        #1;
        release dut.r_state;
        tick();
        check_all("illegal", 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("illegal_after", 3'd0, 1'b0, 1'b1, 1'b0);

        // 5. Lock freezes everything until reset
        do_reset();
        user_input = STEP;
        repeat (3) tick();
        check_all("pre_lock", 3'd3, 1'b0, 1'b0, 1'b0);
        lock_req = 1'b1;
        tick();
        check_all("lock", 3'd3, 1'b0, 1'b0, 1'b1);
        lock_req  = 1'b0;
        jump_tgt  = 3'd7;
        dwell_cfg = 4'd0;
        for (int i = 0; i < 20; i++) begin
            user_input = lock_cmds[i % 3];
            jump_tgt   = (i % 2 == 0) ? 3'd7 : 3'd1;
            tick();
            check({"locked_out", $sformatf("%0d", i)}, {5'd0, out}, 8'd3);
        end
        check_all("locked_end", 3'd3, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 6. Async reset mid-RUN, then dwell restarts from zero
        user_input = RUN;
        dwell_cfg  = 4'd2;
        repeat (7) tick();
        check_all("midrun", 3'd2, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("midrun_rst", 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); check_all("rerun_a", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(); check_all("rerun_b", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(); check_all("rerun_c", 3'd1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
